// File: rtl/rc4_decode_fsm_pkg.sv
// rtl/rc4_decode_fsm_pkg.sv - shared constants and state codes for the RC4 decode stage
package rc4_decode_fsm_pkg;
    localparam int RC4_SBOX_SIZE = 256;
    localparam int IW            = $clog2(RC4_SBOX_SIZE);

    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE = 4'd0;
    localparam state_t ST_RD_I = 4'd1;
    localparam state_t ST_WT_I = 4'd2;
    localparam state_t ST_LT_I = 4'd3;
    localparam state_t ST_RD_J = 4'd4;
    localparam state_t ST_WT_J = 4'd5;
    localparam state_t ST_LT_J = 4'd6;
    localparam state_t ST_WR_I = 4'd7;
    localparam state_t ST_WR_J = 4'd8;
    localparam state_t ST_RD_F = 4'd9;
    localparam state_t ST_WT_F = 4'd10;
    localparam state_t ST_XOR  = 4'd11;
    localparam state_t ST_NXT  = 4'd12;
    localparam state_t ST_DONE = 4'd13;
endpackage

// File: rtl/rc4_decode_fsm_if.sv
// rtl/rc4_decode_fsm_if.sv - controller handshake plus S-memory, message ROM and output RAM ports
interface rc4_decode_fsm_if #(
    parameter int AW = 5
);
    logic          decode_start;
    logic          decode_finish;
    logic          decode_fail;
    logic [7:0]    s_addr;
    logic [7:0]    s_wrdata;
    logic          s_wren;
    logic [7:0]    s_q;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_q;
    logic [AW-1:0] out_addr;
    logic [7:0]    out_wrdata;
    logic          out_wren;

    modport master (
        output decode_start, s_q, rom_q,
        input  decode_finish, decode_fail, s_addr, s_wrdata, s_wren,
               rom_addr, out_addr, out_wrdata, out_wren
    );

    modport slave (
        input  decode_start, s_q, rom_q,
        output decode_finish, decode_fail, s_addr, s_wrdata, s_wren,
               rom_addr, out_addr, out_wrdata, out_wren
    );
endinterface

// File: rtl/rc4_valid_char.sv
// rtl/rc4_valid_char.sv - accepts lowercase ASCII letters and space
module rc4_valid_char
    import rc4_decode_fsm_pkg::*;
(
    input  logic [7:0] i_char,
    output logic       o_valid
);
    assign o_valid = ((i_char >= CHAR_LO) && (i_char <= CHAR_HI)) || (i_char == CHAR_SPACE);
endmodule

// File: rtl/rc4_decode_fsm.sv
// rtl/rc4_decode_fsm.sv - RC4 PRGA decode: swap S, XOR keystream into message, flag non-text bytes
module rc4_decode_fsm
    import rc4_decode_fsm_pkg::*;
#(
    parameter int MSG_LEN     = 32,
    parameter bit EARLY_ABORT = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    rc4_decode_fsm_if.slave bus
);
    localparam int            AW     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [AW-1:0] K_LAST = AW'(MSG_LEN - 1);

    state_t        r_state;
    logic [IW-1:0] r_i;
    logic [IW-1:0] r_j;
    logic [7:0]    r_si;
    logic [7:0]    r_sj;
    logic [AW-1:0] r_k;
    logic          r_fail;

    logic [7:0]    w_plain;
    logic          w_valid;

    assign w_plain = bus.s_q ^ bus.rom_q;

    rc4_valid_char u_valid_char (
        .i_char  (w_plain),
        .o_valid (w_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_si    <= '0;
            r_sj    <= '0;
            r_k     <= '0;
            r_fail  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.decode_start) begin
                        r_i     <= 8'd1;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_fail  <= 1'b0;
                        r_state <= ST_RD_I;
                    end
                end
                ST_LT_I: begin
                    r_si    <= bus.s_q;
                    r_j     <= r_j + bus.s_q;
                    r_state <= ST_RD_J;
                end
                ST_LT_J: begin
                    r_sj    <= bus.s_q;
                    r_state <= ST_WR_I;
                end
                ST_XOR: begin
                    if (!w_valid) begin
                        r_fail <= 1'b1;
                    end
                    r_state <= ST_NXT;
                end
                ST_NXT: begin
                    if ((EARLY_ABORT && r_fail) || (r_k == K_LAST)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_k     <= r_k + AW'(1);
                        r_i     <= r_i + 8'd1;
                        r_state <= ST_RD_I;
                    end
                end
                ST_RD_I, ST_WT_I, ST_RD_J, ST_WT_J, ST_WR_I, ST_WR_J, ST_RD_F, ST_WT_F: begin
                    r_state <= r_state + 4'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Reads are issued twice (RD/WT) so s_q is stable through the following latch/XOR cycle.
    always_comb begin
        bus.s_addr     = 8'd0;
        bus.s_wrdata   = 8'd0;
        bus.s_wren     = 1'b0;
        bus.out_wrdata = 8'd0;
        bus.out_wren   = 1'b0;
        case (r_state)
            ST_RD_I, ST_WT_I: bus.s_addr = r_i;
            ST_RD_J, ST_WT_J: bus.s_addr = r_j;
            ST_WR_I: begin
                bus.s_addr   = r_i;
                bus.s_wrdata = r_sj;
                bus.s_wren   = 1'b1;
            end
            ST_WR_J: begin
                bus.s_addr   = r_j;
                bus.s_wrdata = r_si;
                bus.s_wren   = 1'b1;
            end
            ST_RD_F, ST_WT_F: bus.s_addr = r_si + r_sj;
            ST_XOR: begin
                bus.out_wrdata = w_plain;
                bus.out_wren   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.rom_addr      = r_k;
    assign bus.out_addr      = r_k;
    assign bus.decode_finish = (r_state == ST_DONE);
    assign bus.decode_fail   = r_fail;
endmodule

// File: tb/tb_rc4_decode_fsm.sv
// tb/tb_rc4_decode_fsm.sv - directed vector bench for rc4_decode_fsm with behavioural memories
module tb_rc4_decode_fsm;
    logic clk;
    logic reset_n;
    logic ld;

    rc4_decode_fsm_if #(.AW(3)) ia ();
    rc4_decode_fsm_if #(.AW(3)) ib ();
    rc4_decode_fsm_if #(.AW(1)) ic ();

    rc4_decode_fsm #(.MSG_LEN(8), .EARLY_ABORT(1'b1)) u_a (.clk(clk), .reset_n(reset_n), .bus(ia));
    rc4_decode_fsm #(.MSG_LEN(8), .EARLY_ABORT(1'b0)) u_b (.clk(clk), .reset_n(reset_n), .bus(ib));
    rc4_decode_fsm #(.MSG_LEN(1), .EARLY_ABORT(1'b1)) u_c (.clk(clk), .reset_n(reset_n), .bus(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] sm_a [256];
    logic [7:0] sm_b [256];
    logic [7:0] sm_c [256];
    logic [7:0] rm_a [8];
    logic [7:0] rm_b [8];
    logic [7:0] rm_c [2];
    logic [7:0] om_a [8];
    logic [7:0] om_b [8];
    logic [7:0] om_c [2];
    int         wc_a, wc_b, wc_c;

    // Synchronous-read memories; the read is sampled before the same-edge write lands.
    always @(posedge clk) begin
        ia.s_q   <= sm_a[ia.s_addr];
        ia.rom_q <= rm_a[ia.rom_addr];
        if (ld) begin
            for (int n = 0; n < 256; n++) sm_a[n] = 8'(n);
            wc_a = 0;
        end else begin
            if (ia.s_wren) sm_a[ia.s_addr] = ia.s_wrdata;
            if (ia.out_wren) begin om_a[ia.out_addr] = ia.out_wrdata; wc_a++; end
        end
    end

    always @(posedge clk) begin
        ib.s_q   <= sm_b[ib.s_addr];
        ib.rom_q <= rm_b[ib.rom_addr];
        if (ld) begin
            for (int n = 0; n < 256; n++) sm_b[n] = 8'(n);
            wc_b = 0;
        end else begin
            if (ib.s_wren) sm_b[ib.s_addr] = ib.s_wrdata;
            if (ib.out_wren) begin om_b[ib.out_addr] = ib.out_wrdata; wc_b++; end
        end
    end

    always @(posedge clk) begin
        ic.s_q   <= sm_c[ic.s_addr];
        ic.rom_q <= rm_c[ic.rom_addr];
        if (ld) begin
            for (int n = 0; n < 256; n++) sm_c[n] = 8'(n);
            wc_c = 0;
        end else begin
            if (ic.s_wren) sm_c[ic.s_addr] = ic.s_wrdata;
            if (ic.out_wren) begin om_c[ic.out_addr] = ic.out_wrdata; wc_c++; end
        end
    end

    typedef struct {
        logic [7:0] rom;
        logic [7:0] plain;
    } vec_t;
    vec_t vecs [8];

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       ia.decode_start = v;
            1:       ib.decode_start = v;
            default: ic.decode_start = v;
        endcase
    endtask

    function automatic logic get_fin(input int sel);
        case (sel)
            0:       return ia.decode_finish;
            1:       return ib.decode_finish;
            default: return ic.decode_finish;
        endcase
    endfunction

    function automatic logic get_fail(input int sel);
        case (sel)
            0:       return ia.decode_fail;
            1:       return ib.decode_fail;
            default: return ic.decode_fail;
        endcase
    endfunction

    // Cycle 1 is the start cycle; cyc is the cycle in which finish is seen, -1 on timeout.
    task automatic run_dut(input int sel, input int extra_at, output int cyc, output logic fail_fin);
        int n;
        @(negedge clk);
        set_start(sel, 1'b1);
        n = 1;
        repeat (200) begin
            @(negedge clk);
            n++;
            set_start(sel, n == extra_at);
            if (get_fin(sel)) begin
                cyc      = n;
                fail_fin = get_fail(sel);
                return;
            end
        end
        cyc      = -1;
        fail_fin = 1'bx;
    endtask

    task automatic do_load();
        @(negedge clk);
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    logic [7:0] ms [256];

    task automatic model_sbox(input int nbytes);
        logic [7:0] mi, mj, t;
        for (int n = 0; n < 256; n++) ms[n] = 8'(n);
        mi = 8'd0;
        mj = 8'd0;
        for (int n = 0; n < nbytes; n++) begin
            mi     = mi + 8'd1;
            mj     = mj + ms[mi];
            t      = ms[mi];
            ms[mi] = ms[mj];
            ms[mj] = t;
        end
    endtask

    function automatic logic [33:0] outs_a();
        return {ia.s_addr, ia.s_wrdata, ia.s_wren, ia.rom_addr, ia.out_addr,
                ia.out_wrdata, ia.out_wren, ia.decode_finish, ia.decode_fail};
    endfunction

    int   cyc_a, cyc_b, cyc_c, bad, fins;
    logic f_a, f_b, f_c;

    initial begin
        reset_n = 1'b0;
        ld      = 1'b0;
        ia.decode_start = 1'b0;
        ib.decode_start = 1'b0;
        ic.decode_start = 1'b0;

        // Identity-S keystream is 02 05 07 0D 0D 17 1F 28; plaintext "hr there".
        vecs[0] = '{8'h6A, 8'h68};
        vecs[1] = '{8'h77, 8'h72};
        vecs[2] = '{8'h27, 8'h20};
        vecs[3] = '{8'h79, 8'h74};
        vecs[4] = '{8'h65, 8'h68};
        vecs[5] = '{8'h72, 8'h65};
        vecs[6] = '{8'h6D, 8'h72};
        vecs[7] = '{8'h4D, 8'h65};
        for (int k = 0; k < 8; k++) begin
            rm_a[k] = vecs[k].rom;
            rm_b[k] = vecs[k].rom;
        end
        rm_c[0] = 8'h63;
        rm_c[1] = 8'h00;

        repeat (3) @(negedge clk);
        chk("reset_outputs_a", 64'(outs_a()), 64'd0);
        chk("reset_finish_fail_c", 64'({ic.decode_finish, ic.decode_fail, ic.s_wren, ic.out_wren}), 64'd0);
        reset_n = 1'b1;
        do_load();

        run_dut(2, 0, cyc_c, f_c);
        chk("len1_finish_cycle", 64'(cyc_c), 64'd14);
        chk("len1_out0", 64'(om_c[0]), 64'h61);
        chk("len1_fail", 64'(f_c), 64'd0);

        run_dut(0, 40, cyc_a, f_a);
        chk("valid_finish_cycle", 64'(cyc_a), 64'd98);
        chk("valid_fail_at_finish", 64'(f_a), 64'd0);
        chk("valid_write_count", 64'(wc_a), 64'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("valid_out[%0d]", k), 64'(om_a[k]), 64'(vecs[k].plain));
        end
        chk("sbox_2_after_swap", 64'(sm_a[2]), 64'd3);
        model_sbox(8);
        bad = 0;
        for (int n = 0; n < 256; n++) if (sm_a[n] !== ms[n]) bad++;
        chk("sbox_vs_model", 64'(bad), 64'd0);

        rm_a[3] = 8'h4C;
        rm_b[3] = 8'h4C;
        do_load();
        fork
            run_dut(0, 0, cyc_a, f_a);
            run_dut(1, 0, cyc_b, f_b);
        join
        chk("abort_finish_cycle", 64'(cyc_a), 64'd50);
        chk("abort_write_count", 64'(wc_a), 64'd4);
        chk("abort_fail_at_finish", 64'(f_a), 64'd1);
        chk("full_finish_cycle", 64'(cyc_b), 64'd98);
        chk("full_write_count", 64'(wc_b), 64'd8);
        chk("full_fail_at_finish", 64'(f_b), 64'd1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("full_out[%0d]", k), 64'(om_b[k]), (k == 3) ? 64'h41 : 64'(vecs[k].plain));
        end
        repeat (3) @(negedge clk);
        chk("fail_held_after_finish", 64'(ia.decode_fail), 64'd1);

        rm_a[3] = vecs[3].rom;
        do_load();
        @(negedge clk);
        ia.decode_start = 1'b1;
        @(negedge clk);
        ia.decode_start = 1'b0;
        for (int n = 0; n < 200 && wc_a < 5; n++) @(negedge clk);
        repeat (7) @(negedge clk);
        chk("pre_reset_s_wren", 64'({ia.s_wren, ia.out_addr}), 64'({1'b1, 3'd5}));
        #2 reset_n = 1'b0;
        #1 chk("mid_reset_outputs", 64'(outs_a()), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        fins = 0;
        repeat (30) begin
            @(negedge clk);
            if (ia.decode_finish) fins++;
        end
        chk("no_finish_after_reset", 64'(fins), 64'd0);

        do_load();
        run_dut(0, 0, cyc_a, f_a);
        chk("rerun_finish_cycle", 64'(cyc_a), 64'd98);
        chk("rerun_fail", 64'(f_a), 64'd0);
        bad = 0;
        for (int k = 0; k < 8; k++) if (om_a[k] !== vecs[k].plain) bad++;
        chk("rerun_out_bytes", 64'(bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
